// File: rtl/ft245_sync_tx.sv
// FT245 synchronous FIFO transmit path: drains the TX async FIFO through a
// 2-entry skid buffer and writes words to the FTDI chip under bus arbitration.
//
// Ports:
//   clk, rst            FT clkout domain clock, async active-high reset
//   fifo_ren            read strobe to the TX FIFO read side
//   fifo_rdata/rvalid   FIFO read data, valid one cycle after accepted ren
//   fifo_rempty         FIFO empty flag
//   ft_txe_n            FT chip can accept data (low)
//   ft_wr_n             FT write strobe, active low
//   ft_data, ft_data_oe data to the FT bus and pad drive enable
//   bus_req, bus_grant  shared data bus arbitration with the RX path
//   tx_words            running count of words accepted by the FT chip
module ft245_sync_tx #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 64,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_rvalid,
    input  logic              fifo_rempty,
    input  logic              ft_txe_n,
    output logic              ft_wr_n,
    output logic [DATA_W-1:0] ft_data,
    output logic              ft_data_oe,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [CNT_W-1:0]  tx_words
);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        WRITE,
        RELEASE
    } state_t;

    // Wide enough to hold BURST_MAX; one bit when bursts are unlimited.
    localparam int BW = $clog2(BURST_MAX + 2);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [BW-1:0]     burst;
    logic [BW-1:0]     burst_inc;
    logic [2:0]        fill_nxt;
    logic              has_data;
    logic              accept;
    logic              empty_nxt;
    logic              burst_full;

    assign has_data  = (count != 2'd0);
    assign accept    = ~ft_wr_n & ~ft_txe_n;
    assign fill_nxt  = {1'b0, count} + {2'b00, fifo_rvalid}
                     - {2'b00, accept};
    assign empty_nxt = (fill_nxt == 3'd0) & fifo_rempty;
    assign burst_inc = burst + BW'(1);
    assign burst_full = (BURST_MAX != 0) && accept
                     && (burst_inc == BW'(BURST_MAX));

    // Prefetch whenever the buffer will still have room after this edge,
    // counting the word already in flight from the FIFO.
    assign fifo_ren = ~rst & ~fifo_rempty & (fill_nxt < 3'd2);

    assign ft_data = mem[rd_ptr];

    always_comb begin
        state_nxt  = state;
        ft_wr_n    = 1'b1;
        ft_data_oe = 1'b0;
        bus_req    = 1'b0;
        unique case (state)
            IDLE: begin
                bus_req = ~rst & ~ft_txe_n & (has_data | ~fifo_rempty);
                if (bus_req & bus_grant) state_nxt = TURN;
            end
            TURN: begin
                ft_data_oe = 1'b1;
                bus_req    = 1'b1;
                state_nxt  = WRITE;
            end
            WRITE: begin
                ft_data_oe = 1'b1;
                bus_req    = 1'b1;
                ft_wr_n    = ~has_data;
                if (ft_txe_n | ~bus_grant | empty_nxt | burst_full)
                    state_nxt = RELEASE;
            end
            RELEASE: begin
                ft_data_oe = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            burst    <= '0;
            tx_words <= '0;
        end else begin
            state <= state_nxt;
            count <= fill_nxt[1:0];
            if (fifo_rvalid) begin
                mem[wr_ptr] <= fifo_rdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (accept) begin
                rd_ptr   <= ~rd_ptr;
                tx_words <= tx_words + CNT_W'(1);
            end
            if (state == TURN)
                burst <= '0;
            else if (accept)
                burst <= burst_inc;
        end
    end

endmodule

// File: doc/ft245_sync_tx.md
Name: ft245_sync_tx

Overview:
Transmit-path controller for the FT245 synchronous FIFO bus. It is the consumer at the read side of the TX async FIFO, which sits in the FT clock domain. It drains FIFO words through a 2-entry skid buffer and writes them to the FTDI chip using txe_n/wr_n. It shares the bidirectional data bus with the RX path through an external arbiter (bus_req/bus_grant).

Parameters:
DATA_W, 8, FIFO and FT data width
BURST_MAX, 64, max words per bus ownership; 0 = unlimited
CNT_W, 32, width of tx_words counter

Ports:
clk  input  1  FT clkout domain clock
rst  input  1  asynchronous, active-high reset
fifo_ren  output  1  read strobe to FIFO read side
fifo_rdata  input  DATA_W  FIFO read data, valid when fifo_rvalid=1
fifo_rvalid  input  1  FIFO data valid, 1 cycle after accepted fifo_ren
fifo_rempty  input  1  FIFO empty flag
ft_txe_n  input  1  FT chip can accept data (low)
ft_wr_n  output  1  FT write strobe, active low
ft_data  output  DATA_W  data to FT bus
ft_data_oe  output  1  drive enable for bus pads
bus_req  output  1  request for bus ownership
bus_grant  input  1  bus granted to TX path
tx_words  output  CNT_W  total words accepted by FT, wraps

Behaviour:
- Reset (async, active-high): state IDLE, buffer count 0, ft_wr_n=1, ft_data_oe=0, bus_req=0, fifo_ren=0, ft_data=0, tx_words=0, burst count 0. Any words held in the buffer are discarded; this loss is expected.
- Skid buffer: 2-entry FIFO inside the block.
  - push = fifo_rvalid (fifo_rdata captured).
  - pop = accept = ~ft_wr_n & ~ft_txe_n at the clk edge.
  - Push and pop may occur in the same cycle; count is unchanged.
- fifo_ren = ~fifo_rempty & (count + fifo_rvalid - pop < 2), in all states including IDLE (prefetch).
  - Buffer must never overflow. The bench asserts count<=2.
  - Steady state gives 1 word/cycle throughput.
- ft_data = buffer head. It is held stable while not accepted.
- ft_wr_n and ft_data_oe are decoded only from registered state and count. There is no combinational path from ft_txe_n or bus_grant.
- FSM:
  - IDLE: oe=0, wr_n=1. bus_req=1 when ~ft_txe_n & (count>0 | ~fifo_rempty). Go to TURN when bus_req & bus_grant.
  - TURN: 1 cycle. oe=1, wr_n=1, bus_req=1. Burst count cleared. Go to WRITE.
  - WRITE: oe=1, bus_req=1, wr_n = ~(count>0).
    - Each accept increments burst count and tx_words (mod 2^CNT_W).
    - Go to RELEASE when any of these holds at the edge: ft_txe_n=1; bus_grant=0; count - pop + fifo_rvalid = 0 with fifo_rempty=1; burst count after increment = BURST_MAX (BURST_MAX≠0).
  - RELEASE: 1 cycle. oe=1, wr_n=1, bus_req=0. Go to IDLE.
- txe_n high during WRITE: the word on the bus at that edge is not accepted. It stays at the head and is the first word of the next burst. No duplication, no loss.
- bus_grant dropping in WRITE is handled like txe_n: the current-edge word is accepted only if txe_n=0. Then RELEASE.
- Latency: from IDLE with data ready and grant, first ft_wr_n low occurs 2 cycles after bus_req rises (TURN, then WRITE).
- Word order at ft_data equals FIFO order.

Test Plan:
- Reset: assert rst mid-burst (wr_n low, 2 words buffered) -> immediately ft_wr_n=1, ft_data_oe=0, bus_req=0, tx_words=0. After release, the FIFO's remaining words are sent correctly.
- FIFO preloaded 0xA0..0xA3, txe_n=0, grant tied 1 -> bus_req, TURN, then ft_wr_n low 4 consecutive cycles with A0,A1,A2,A3, then RELEASE, IDLE. tx_words=4.
- 6 words 0x10..0x15; txe_n high at the edge presenting 0x12 -> 0x12 not accepted, RELEASE. txe_n low again -> new burst starts with 0x12. FT receives 0x10..0x15 exactly once; tx_words=6.
- BURST_MAX=4, 10 words, txe_n=0 -> bursts of 4,4,2. Each burst is separated by RELEASE/IDLE/TURN with oe=0 in IDLE.
- bus_grant dropped after 3rd accepted word of 8 -> RELEASE next cycle, bus_req=0 for 1 cycle, then re-requested. The remaining 5 words follow in order.
- Random txe_n/grant/FIFO-empty toggling, 10k words -> scoreboard matches order; buffer count never >2; wr_n never low while oe=0.
